// File: rtl/feature_store_19_if.sv
// Bus between the layer datapath / RAM write port and feature_store_19.
// The sum output exists only when FEATURE_STORE_SUM_EN is defined.
interface feature_store_19_if #(
    parameter int N    = 288,
    parameter int DLEN = 16,
    parameter int AW   = 11
);
    logic [3:0]        cs;
    logic              start;
    logic [N*DLEN-1:0] d;
    logic              wr_ready;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DLEN-1:0]   wdata;
    logic              busy;
    logic              done;
    logic              err;
`ifdef FEATURE_STORE_SUM_EN
    logic [DLEN+9:0]   sum;

    modport slave  (input  cs, start, d, wr_ready,
                    output we, waddr, wdata, busy, done, err, sum);
    modport master (output cs, start, d, wr_ready,
                    input  we, waddr, wdata, busy, done, err, sum);
`else
    modport slave  (input  cs, start, d, wr_ready,
                    output we, waddr, wdata, busy, done, err);
    modport master (output cs, start, d, wr_ready,
                    input  we, waddr, wdata, busy, done, err);
`endif
endinterface

// File: rtl/feature_store_19.sv
// Captures an N-word result vector and writes it word by word into the feature RAM at the layer base.
// Optional accumulator of written words enabled by defining FEATURE_STORE_SUM_EN.
module feature_store_19 #(
    parameter int         N      = 288,
    parameter int         DLEN   = 16,
    parameter int         AW     = 11,
    parameter logic [3:0] LAYER0 = 4'd0,
    parameter logic [3:0] LAYER1 = 4'd1,
    parameter logic [3:0] LAYER2 = 4'd2,
    parameter logic [3:0] LAYER3 = 4'd3,
    parameter logic [3:0] AFFINE = 4'd4
) (
    input  logic            clk,
    input  logic            rst,
    feature_store_19_if.slave bus
);
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t          r_state;
    logic [DLEN-1:0] r_buf [N];
    logic [IW-1:0]   r_idx;
    logic [AW-1:0]   r_base;
    logic [3:0]      r_cs_prev;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DLEN-1:0] r_wdata;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
`ifdef FEATURE_STORE_SUM_EN
    logic [DLEN+9:0] r_sum;
`endif

    logic            w_capture;
    logic [IW-1:0]   w_next_idx;

    function automatic logic cs_valid(input logic [3:0] c);
        return c inside {LAYER0, LAYER1, LAYER2, LAYER3, AFFINE};
    endfunction

    function automatic logic [AW-1:0] base_of(input logic [3:0] c);
        case (c)
            LAYER1:  return AW'(N);
            LAYER2:  return AW'(2 * N);
            LAYER3:  return AW'(3 * N);
            AFFINE:  return AW'(4 * N);
            default: return '0;
        endcase
    endfunction

    assign w_capture  = (r_state == S_IDLE) && bus.start && cs_valid(bus.cs);
    assign w_next_idx = r_idx + 1'b1;

    // Only the captured copy is written, so d is free to change after the capture cycle.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= bus.d[i*DLEN +: DLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_cs_prev <= bus.cs;
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_base  <= '0;
`ifdef FEATURE_STORE_SUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cs_valid(bus.cs)) begin
                            r_base  <= base_of(bus.cs);
                            r_idx   <= '0;
                            r_we    <= 1'b1;
                            r_waddr <= base_of(bus.cs);
                            r_wdata <= bus.d[DLEN-1:0];
                            r_busy  <= 1'b1;
                            r_state <= S_WRITE;
`ifdef FEATURE_STORE_SUM_EN
                            r_sum   <= '0;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // A layer switch mid-vector would scatter words across slots: abort instead.
                    if (bus.cs != r_cs_prev) begin
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_we && bus.wr_ready) begin
`ifdef FEATURE_STORE_SUM_EN
                        r_sum <= r_sum + {10'd0, r_wdata};
`endif
                        if (r_idx == IW'(N - 1)) begin
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_waddr <= r_base + AW'(w_next_idx);
                            r_wdata <= r_buf[w_next_idx];
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.we    = r_we;
    assign bus.waddr = r_waddr;
    assign bus.wdata = r_wdata;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
`ifdef FEATURE_STORE_SUM_EN
    assign bus.sum   = r_sum;
`endif
endmodule

// File: tb/tb_feature_store_19.sv
// Bench for feature_store_19: directed scenarios plus random data/ready, checked against an
// ordered model of the expected RAM write stream.
module tb_feature_store_19;
    localparam int N    = 288;
    localparam int DLEN = 16;
    localparam int AW   = 11;
    localparam logic [3:0] L0  = 4'd0;
    localparam logic [3:0] L1  = 4'd1;
    localparam logic [3:0] L2  = 4'd2;
    localparam logic [3:0] L3  = 4'd3;
    localparam logic [3:0] AFF = 4'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    feature_store_19_if #(.N(N), .DLEN(DLEN), .AW(AW)) bus ();
    feature_store_19 #(.N(N), .DLEN(DLEN), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [DLEN-1:0] words [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       words[i] = DLEN'(i);
                1:       words[i] = DLEN'(N - 1 - i);
                default: words[i] = DLEN'($urandom());
            endcase
        end
    endtask

    task automatic load_d();
        for (int i = 0; i < N; i++) bus.d[i*DLEN +: DLEN] = words[i];
    endtask

    task automatic scramble_d();
        for (int i = 0; i < (N * DLEN) / 32; i++) bus.d[i*32 +: 32] = $urandom();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " we"},    64'(bus.we),    64'd0);
        chk({tag, " waddr"}, 64'(bus.waddr), 64'd0);
        chk({tag, " wdata"}, 64'(bus.wdata), 64'd0);
        chk({tag, " busy"},  64'(bus.busy),  64'd0);
        chk({tag, " done"},  64'(bus.done),  64'd0);
        chk({tag, " err"},   64'(bus.err),   64'd0);
`ifdef FEATURE_STORE_SUM_EN
        chk({tag, " sum"},   64'(bus.sum),   64'd0);
`endif
    endtask

    // mode: 0 ready always high, 1 ready 1,0,1,0..., 2 random ready.
    // abort_at >= 0: switch cs to abort_cs when that many words have been accepted.
    task automatic store(input string tag, input logic [3:0] code, input int base, input int mode,
                         input int abort_at, input logic [3:0] abort_cs, input bit extra_start);
        int acc, done_seen, done_cyc, last_acc_cyc, abort_cyc;
        logic [63:0] exp_sum;
        logic stall, r, aborted;
        logic [AW-1:0] h_addr;
        logic [DLEN-1:0] h_data;
        acc = 0; done_seen = 0; done_cyc = 0; last_acc_cyc = 0; abort_cyc = 0;
        exp_sum = '0; stall = 1'b0; aborted = 1'b0; h_addr = '0; h_data = '0;
        @(negedge clk);
        bus.cs = code; load_d(); bus.start = 1'b1; bus.wr_ready = 1'b0;
        for (int cyc = 1; cyc <= 4 * N + 8; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 1) begin
                scramble_d();
                chk({tag, " first we"},   64'(bus.we),    64'd1);
                chk({tag, " first busy"}, 64'(bus.busy),  64'd1);
            end
            if (extra_start && cyc == N / 2) begin
                bus.start = 1'b1;
                scramble_d();
            end
            if (stall && !aborted) begin
                chk({tag, " hold we"},    64'(bus.we),    64'd1);
                chk({tag, " hold waddr"}, 64'(bus.waddr), 64'(h_addr));
                chk({tag, " hold wdata"}, 64'(bus.wdata), 64'(h_data));
            end
            if (bus.done) begin
                done_seen++;
                done_cyc = cyc;
                chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
                chk({tag, " words at done"}, 64'(acc), 64'(N));
                chk({tag, " done timing"}, 64'(cyc), 64'(last_acc_cyc + 1));
`ifdef FEATURE_STORE_SUM_EN
                chk({tag, " sum"}, 64'(bus.sum), exp_sum);
`endif
            end
            if (aborted && cyc == abort_cyc + 1) begin
                chk({tag, " abort we"},   64'(bus.we),   64'd0);
                chk({tag, " abort busy"}, 64'(bus.busy), 64'd0);
                chk({tag, " abort err"},  64'(bus.err),  64'd1);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && !aborted && acc == abort_at && bus.we) begin
                bus.cs = abort_cs;
                r = 1'b0;
                aborted = 1'b1;
                abort_cyc = cyc;
            end
            bus.wr_ready = r;
            stall  = bus.we && !r;
            h_addr = bus.waddr;
            h_data = bus.wdata;
            if (bus.we && r) begin
                if (acc < N) begin
                    chk({tag, " waddr"}, 64'(bus.waddr), 64'(base + acc));
                    chk({tag, " wdata"}, 64'(bus.wdata), 64'(words[acc]));
                    exp_sum = exp_sum + 64'(words[acc]);
                end else begin
                    chk({tag, " extra we"}, 64'(bus.we), 64'd0);
                end
                acc++;
                last_acc_cyc = cyc;
            end
            if (done_seen > 0 && cyc > done_cyc + 2) break;
            if (aborted && cyc > abort_cyc + 5) break;
        end
        if (aborted) begin
            chk({tag, " no done after abort"}, 64'(done_seen), 64'd0);
            chk({tag, " words before abort"}, 64'(acc), 64'(abort_at));
        end else begin
            chk({tag, " done count"}, 64'(done_seen), 64'd1);
            if (mode == 0) chk({tag, " done latency"}, 64'(done_cyc), 64'(N + 1));
            if (mode == 1) chk({tag, " done latency"}, 64'(done_cyc), 64'(2 * N));
        end
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.wr_ready = 1'b0; bus.cs = L0; bus.d = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle we", 64'(bus.we), 64'd0);

        // T1 with a second start mid-run (T5 part 2)
        fill(0);
        store("T1", L0, 0, 0, -1, L0, 1'b1);
        chk("T1 err", 64'(bus.err), 64'd0);

        // T5: invalid layer code
        @(negedge clk);
        bus.cs = 4'hF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("T5 we",   64'(bus.we),   64'd0);
        chk("T5 busy", 64'(bus.busy), 64'd0);
        chk("T5 err",  64'(bus.err),  64'd1);
        @(negedge clk);
        bus.cs = L0;
        chk("T5 still idle", 64'(bus.we), 64'd0);
        chk("T5 err sticky", 64'(bus.err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("T5 rst");

        fill(1);
        store("T2", AFF, 4 * N, 0, -1, AFF, 1'b0);
        fill(2);
        store("T3", L2, 2 * N, 1, -1, L2, 1'b0);
        fill(2);
        store("RND", L1, N, 2, -1, L1, 1'b0);
        fill(2);
        store("T4", L1, N, 0, 100, L3, 1'b0);
        fill(2);
        store("T4b", L3, 3 * N, 0, -1, L3, 1'b0);
        chk("T4b err sticky", 64'(bus.err), 64'd1);

        // T6: reset in the middle of a write
        fill(0);
        @(negedge clk);
        bus.cs = L0; load_d(); bus.start = 1'b1; bus.wr_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("T6 busy before rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("T6 mid rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("T6 we after rst", 64'(bus.we), 64'd0);
        chk("T6 busy after rst", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
